// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared FSM encodings and fetch constants for the fetch front end
package inst_fetch_pkg;
  typedef enum logic {FETCH_RUN, FETCH_FAULT} fetch_state_e;
  localparam int INST_W = 32;
  localparam int PC_INC = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with clear; caller gates push/pop against full/empty
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign pop_data = mem[rd];
  assign empty    = count == '0;
  assign full     = count == (AW+1)'(DEPTH);
  // storage and pointers; clear wins over a same-cycle push or pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr] <= push_data;
        wr      <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch front end; optional misaligned-redirect fault via FETCH_MISALIGN_EN
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_MISALIGN_EN
  localparam int FW = XLEN + INST_W + 1;
`else
  localparam int FW = XLEN + INST_W;
`endif
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc, q_pc;
  logic [CW-1:0]   drop, q_count, o_count;
  logic            q_full, q_empty, o_full, o_empty;
  logic            grant, resp_pop, o_pop, o_push, push_req, credit, misaligned;
  logic [FW-1:0]   o_din, o_dout;
  assign resp_pop  = imem_rvalid && !q_empty;
  assign o_pop     = !o_empty && out_ready;
  // the entry leaving the FIFO this cycle frees its slot for a new fetch
  assign credit    = ({1'b0, q_count} + {1'b0, o_count} - {{CW{1'b0}}, o_pop}) < DEPTH_C;
  assign imem_req  = reset_n && state_q == FETCH_RUN && !redirect_valid && credit;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign o_push    = push_req && (!o_full || o_pop);
  assign out_valid = !o_empty;
  assign out_pc    = o_dout[FW-1 -: XLEN];
  assign out_inst  = o_dout[FW-XLEN-1 -: INST_W];
`ifdef FETCH_MISALIGN_EN
  logic            fault_q;
  logic [XLEN-1:0] fault_pc;
  assign misaligned = |redirect_pc[1:0];
  assign push_req   = fault_q || (resp_pop && drop == '0);
  assign o_din      = fault_q ? {fault_pc, {INST_W{1'b0}}, 1'b1} : {q_pc, imem_rdata, 1'b0};
  assign out_fault  = o_dout[0];
  // a misaligned redirect leaves a single fault entry behind on the following cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault_q  <= 1'b0;
      fault_pc <= '0;
    end else begin
      fault_q  <= redirect_valid && misaligned;
      fault_pc <= redirect_pc;
    end
  end
`else
  assign misaligned = 1'b0;
  assign push_req   = resp_pop && drop == '0;
  assign o_din      = {q_pc, imem_rdata};
  assign out_fault  = 1'b0;
`endif
  // next state: any redirect picks RUN or FAULT from target alignment
  always_comb begin
    state_d = redirect_valid ? (misaligned ? FETCH_FAULT : FETCH_RUN) : state_q;
  end
  // state, fetch PC and stale-response drop counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_RUN;
      pc      <= RESET_PC;
      drop    <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc   <= redirect_pc & ~XLEN'(3);
        drop <= q_count - CW'(resp_pop);
      end else begin
        if (grant) pc <= pc + XLEN'(PC_INC);
        if (resp_pop && drop != '0) drop <= drop - CW'(1);
      end
    end
  end
  fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clock(clock), .reset_n(reset_n), .clear(1'b0),
    .push(grant && !q_full), .push_data(pc), .pop(resp_pop), .pop_data(q_pc),
    .full(q_full), .empty(q_empty), .count(q_count)
  );
  fetch_fifo #(.W(FW), .DEPTH(DEPTH)) u_out_fifo (
    .clock(clock), .reset_n(reset_n), .clear(redirect_valid),
    .push(o_push), .push_data(o_din), .pop(o_pop), .pop_data(o_dout),
    .full(o_full), .empty(o_empty), .count(o_count)
  );
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch front end. Drives the instruction-memory request/response port, tracks the PC of every in-flight fetch, and buffers returned words in a small FIFO. Hands `{pc, inst}` pairs to decode through a valid/ready handshake. Accepts redirects from execute (taken branch, jump, `fence.i` flush) and discards every stale response still in flight.

## Interface
Parameters:
- `XLEN`, 32, PC / address width
- `RESET_PC`, 0, first fetch address after reset
- `DEPTH`, 2, FIFO entries and maximum in-flight fetches; power of two, ≥ 2

Ports:
- `clock` in 1: sole clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `redirect_valid` in 1: redirect the fetch stream this cycle
- `redirect_pc` in XLEN: new fetch PC
- `imem_req` out 1: fetch request
- `imem_addr` out XLEN: fetch address, word aligned
- `imem_gnt` in 1: request accepted this cycle
- `imem_rvalid` in 1: response valid; responses return in order, at most one per cycle, at least one cycle after the grant
- `imem_rdata` in 32: response word
- `out_valid` out 1: entry available to decode
- `out_ready` in 1: decode accepts the entry
- `out_pc` out XLEN: PC of the entry
- `out_inst` out 32: instruction word of the entry
- `out_fault` out 1: entry is a misaligned-target fault (see Configuration)

## Operation
- State: `pc`, `inflight` counter (0..DEPTH), `drop` counter (0..DEPTH), PC queue (DEPTH entries, PC captured at grant), output FIFO (DEPTH entries of `{pc, inst, fault}`), FSM.
- FSM states: RUN, FAULT.
  - Reset enters RUN.
  - A redirect with a misaligned target (macro only) enters FAULT.
  - Any aligned redirect returns to RUN.
- In RUN, `imem_req = !redirect_valid && (inflight + fifo_count < DEPTH)`. `imem_req` is low in FAULT.
- `imem_addr = pc`. `pc` changes only on grant or redirect. A request that has not been granted may be withdrawn.
- Grant: push `pc` into the PC queue, `inflight += 1`, `pc += 4` (modulo 2^XLEN, wraps silently).
- Response:
  - Always pop the PC queue and decrement `inflight`.
  - If `drop > 0`: discard the word and decrement `drop`.
  - Otherwise: push `{popped pc, imem_rdata, 0}` into the FIFO.
  - FIFO space is guaranteed by the credit rule, so the FIFO never overflows.
- Output: `out_*` reflect the FIFO head. A pop occurs on `out_valid && out_ready`.
- Redirect cycle:
  - Clear the FIFO, including any push or pop attempted that cycle.
  - Set `drop` to the number of fetches still in flight after this cycle's response is accounted for. A response arriving in the redirect cycle is discarded.
  - Set `pc <= {redirect_pc[XLEN-1:2], 2'b00}`.
- `imem_req` is low in the redirect cycle, so a grant cannot occur in that cycle.
- Redirect while `drop > 0`: `drop` reloads per the rule above. Grants and responses keep their in-order accounting.
- Simultaneous push and pop on a full FIFO is legal. The count stays unchanged.

## Timing
- Reset values:
  - `imem_req` is 0 while `reset_n` is low; `imem_addr = RESET_PC`.
  - `out_valid = 0`, `out_pc = 0`, `out_inst = 0`, `out_fault = 0`.
  - All counters 0; FSM in RUN.
- First request: the first cycle after `reset_n` deasserts.
- Latency: grant at cycle t, rvalid at t+1, `out_valid` at t+2 (FIFO is registered).
- Redirect at t gives a request at t+1; with a zero-wait memory, `out_valid` for the target at t+3. `out_valid` is low at t+1.
- Throughput with DEPTH ≥ 2, single-cycle memory, and `out_ready` held high: one instruction per cycle.
- `out_*` stay stable while `out_valid && !out_ready`, unless a redirect clears them.
- Reset assertion mid-operation abandons all in-flight fetches. The memory side is reset together with this block.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` enters FAULT.
  - The next cycle, the FIFO receives one entry `{redirect_pc, 32'h0, 1}`.
  - No further requests are issued until the next redirect.
  - Stale in-flight responses are still dropped.
- Not defined:
  - `redirect_pc[1:0]` is ignored (forced to 00).
  - FAULT is never entered.
  - `out_fault` is tied to 0.

## Structure
- Shared package / `defines.vh`: FSM state encodings (`FETCH_RUN`, `FETCH_FAULT`), the instruction-width constant (32) and the PC increment (4).
- One sub-module: `fetch_fifo`.
  - Parameterised width and DEPTH.
  - Synchronous clear input.
  - Push, pop, `full`, `empty`, `count` outputs.
  - Instantiated twice: once as the PC queue, once as the output FIFO.

## Test plan
- Reset with RESET_PC=0x80000000, zero-wait memory, `out_ready=1` -> outputs 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, first `out_valid` at cycle 2 after reset release.
- Backpressure: `out_ready=0` for 5 cycles -> at most DEPTH grants, `imem_req` low when full, `out_pc` held at 0x0; release gives in-order delivery with no loss.
- Redirect to 0x100 with 2 fetches in flight and FIFO full -> both stale responses dropped, FIFO cleared, next outputs 0x100, 0x104.
- Redirect in the same cycle as `imem_rvalid` -> that word is never output; `drop` is correct; the stream resumes at the target.
- Wrap: pc 0xFFFFFFFC -> next fetch address 0x00000000.
- With `FETCH_MISALIGN_EN`, redirect to 0x102 -> one entry with `out_fault=1`, `out_pc=0x102`, `out_inst=0`; `imem_req` stays low until a redirect to 0x200 resumes fetching.
